// File: rtl/trashbin_periph_pkg.sv
// trashbin_periph_pkg: register map, status bit positions and shifter states shared by peripherals
package trashbin_periph_pkg;
    localparam logic [1:0] UART_REG_TXDATA = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_BAUDDIV = 2'd2;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_FULL = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVERFLOW = 3;
    localparam int STATUS_COUNT = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} shifterState_t;
endpackage

// File: rtl/uart_tx_peripheral_if.sv
// uart_tx_peripheral_if: peripheral bus bundle between the memory controller and a slave
interface uart_tx_peripheral_if;
    logic [13:0] AddressBus_P;
    logic [31:0] DataWriteBus_P;
    logic WriteAssert_P;
    logic ReadAssert_P;
    logic [31:0] DataReadBus_P;
    modport master (output AddressBus_P, DataWriteBus_P, WriteAssert_P, ReadAssert_P, input DataReadBus_P);
    modport slave (input AddressBus_P, DataWriteBus_P, WriteAssert_P, ReadAssert_P, output DataReadBus_P);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO where a push into a full FIFO still lands if a pop frees a slot on the same edge
module uart_tx_fifo #(
    parameter int FifoDepth = 8,
    localparam int PtrWidth = $clog2(FifoDepth)
) (
    input  logic CoreClock,
    input  logic Reset,
    input  logic Push,
    input  logic Pop,
    input  logic [7:0] PushData,
    output logic [7:0] PopData,
    output logic Full,
    output logic Empty,
    output logic [PtrWidth:0] Count
);
    logic [7:0] mem [FifoDepth];
    logic [PtrWidth-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign doPop = Pop && !Empty;
    assign doPush = Push && (!Full || doPop);
    assign Full = Count == (PtrWidth+1)'(FifoDepth);
    assign Empty = Count == '0;
    assign PopData = mem[rdPtr];
    always_ff @(posedge CoreClock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            Count <= Count + (PtrWidth+1)'(doPush) - (PtrWidth+1)'(doPop);
        end
    end
    always_ff @(posedge CoreClock) begin
        if (doPush) mem[wrPtr] <= PushData;
    end
endmodule

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 transmitter with TX FIFO, status and baud divisor registers
module uart_tx_peripheral
    import trashbin_periph_pkg::*;
#(
    parameter logic [13:0] BaseAddress = 14'h0010,
    parameter int FifoDepth = 8,
    parameter logic [15:0] DefaultDivisor = 16'd433
) (
    input  logic CoreClock,
    input  logic Reset,
    uart_tx_peripheral_if.slave Bus,
    output logic TxOut,
    output logic TxIrq
);
    localparam int CountWidth = $clog2(FifoDepth) + 1;
    logic selected, wrTx, wrDiv, rdStatus, fifoPop, fifoFull, fifoEmpty, overflow, overflowSet, bitEnd;
    logic [1:0] offset;
    logic [7:0] fifoData, shiftReg;
    logic [CountWidth-1:0] fifoCount;
    logic [15:0] baudDiv, shadowDiv, baudCnt;
    logic [2:0] bitIdx;
    logic [31:0] status, readValue;
    logic unusedWriteBits;
    shifterState_t state;
    assign unusedWriteBits = ^Bus.DataWriteBus_P[31:16];
    assign selected = Bus.AddressBus_P[13:2] == BaseAddress[13:2];
    assign offset = Bus.AddressBus_P[1:0];
    assign wrTx = selected && Bus.WriteAssert_P && offset == UART_REG_TXDATA;
    assign wrDiv = selected && Bus.WriteAssert_P && offset == UART_REG_BAUDDIV;
    assign rdStatus = selected && Bus.ReadAssert_P && offset == UART_REG_STATUS;
    assign bitEnd = baudCnt == shadowDiv;
    // Popping straight out of STOP keeps back-to-back frames gapless
    assign fifoPop = !fifoEmpty && (state == IDLE || (state == STOP && bitEnd));
    assign overflowSet = wrTx && fifoFull && !fifoPop;
    always_comb begin
        status = '0;
        status[STATUS_BUSY] = !fifoEmpty || state != IDLE;
        status[STATUS_FULL] = fifoFull;
        status[STATUS_EMPTY] = fifoEmpty;
        status[STATUS_OVERFLOW] = overflow;
        status[STATUS_COUNT +: CountWidth] = fifoCount;
    end
    assign readValue = offset == UART_REG_STATUS ? status :
                       offset == UART_REG_BAUDDIV ? {16'd0, baudDiv} : '0;
    uart_tx_fifo #(.FifoDepth(FifoDepth)) fifo (
        .CoreClock(CoreClock), .Reset(Reset), .Push(wrTx), .Pop(fifoPop),
        .PushData(Bus.DataWriteBus_P[7:0]), .PopData(fifoData),
        .Full(fifoFull), .Empty(fifoEmpty), .Count(fifoCount)
    );
    always_ff @(posedge CoreClock or posedge Reset) begin
        if (Reset) begin
            baudDiv <= DefaultDivisor;
            overflow <= 1'b0;
            Bus.DataReadBus_P <= '0;
            TxIrq <= 1'b1;
        end else begin
            if (wrDiv) baudDiv <= Bus.DataWriteBus_P[15:0];
            overflow <= overflowSet || (overflow && !rdStatus);
            Bus.DataReadBus_P <= (selected && Bus.ReadAssert_P) ? readValue : '0;
            TxIrq <= fifoEmpty && state == IDLE;
        end
    end
    always_ff @(posedge CoreClock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            TxOut <= 1'b1;
            shiftReg <= '0;
            shadowDiv <= '0;
            baudCnt <= '0;
            bitIdx <= '0;
        end else if (fifoPop) begin
            state <= START;
            TxOut <= 1'b0;
            shiftReg <= fifoData;
            shadowDiv <= baudDiv;
            baudCnt <= '0;
        end else if (state != IDLE) begin
            baudCnt <= bitEnd ? '0 : baudCnt + 16'd1;
            if (bitEnd) begin
                case (state)
                    START: begin
                        state <= DATA;
                        TxOut <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitIdx <= '0;
                    end
                    DATA: begin
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                            TxOut <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            TxOut <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_peripheral.md
# uart_tx_peripheral

Memory-mapped UART transmitter on the SoC peripheral bus, a sibling of the GPIO controller downstream of the memory controller's peripheral port. The CPU writes bytes into a small FIFO. A baud-rate shifter serialises them as 8N1 frames on `TxOut`. Status and divisor registers are readable over the same bus, and reads are registered like the rest of the memory system.

## Interface
Parameters:
- `BaseAddress`, default 14'h0010: peripheral word address of register 0. Must be 4-word aligned.
- `FifoDepth`, default 8: TX FIFO entries. Power of two, ≥2.
- `DefaultDivisor`, default 16'd433: reset value of BAUDDIV.

Ports:
- `CoreClock`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `AddressBus_P`, in, 14: peripheral word address.
- `DataWriteBus_P`, in, 32: write data.
- `WriteAssert_P`, in, 1: single-cycle write strobe.
- `ReadAssert_P`, in, 1: single-cycle read strobe.
- `DataReadBus_P`, out, 32: registered read data. 0 when not selected.
- `TxOut`, out, 1: serial line, idle high.
- `TxIrq`, out, 1: registered level, high when FIFO empty and shifter idle.

## Operation
- Select is `AddressBus_P[13:2] == BaseAddress[13:2]`. The offset is `AddressBus_P[1:0]`.
- Offset 0, TXDATA (write only): a write pushes `DataWriteBus_P[7:0]`. Reads return 0.
- Offset 1, STATUS (read only):
  - [0] Busy: FIFO non-empty or shifter not IDLE.
  - [1] Full.
  - [2] Empty.
  - [3] Overflow: sticky.
  - [8 +: $clog2(FifoDepth)+1]: FIFO count.
  - Other bits 0.
- Offset 2, BAUDDIV (read/write, [15:0]): bit period = BAUDDIV+1 cycles. BAUDDIV=0 gives 1 cycle per bit.
- Offset 3: reserved. Writes ignored, reads return 0.
- Push to a full FIFO:
  - Data dropped and Overflow set.
  - If a pop occurs on the same edge, the push is accepted and count is unchanged.
- Overflow clears on a STATUS read. If an overflowing write coincides with a STATUS read, Overflow stays set.
- Shifter FSM:
  - IDLE: if FIFO non-empty, pop, latch the byte and BAUDDIV into shadow registers, go to START.
  - START: `TxOut`=0 for one bit period, then DATA.
  - DATA: bits 0..7, LSB first, one bit period each. A 3-bit index counts; after bit 7, go to STOP.
  - STOP: `TxOut`=1 for one bit period, then IDLE.
- A BAUDDIV write mid-frame affects only the next frame, via the shadow register.
- Reset values:
  - `TxOut`=1, `TxIrq`=1, `DataReadBus_P`=0.
  - FIFO empty, Overflow=0, BAUDDIV=`DefaultDivisor`, FSM IDLE.
- Reset mid-frame: `TxOut` goes high immediately (asynchronous), the FIFO is flushed, and the frame is lost.

## Timing
- A write is sampled at edge E0. The FIFO is non-empty after E0.
- IDLE pops at E1. `TxOut` falls after E1, so back-to-back frames have no extra idle cycles.
- A frame is exactly 10×(BAUDDIV+1) cycles.
- A read is sampled at edge R0. `DataReadBus_P` holds the value after R0 for one cycle, then returns to 0.
- STATUS reflects state before the R0 edge.
- `DataReadBus_P` is 0 whenever the previous cycle had no selected read, so it can be OR-merged with other peripherals.
- `TxIrq` is registered: it rises one cycle after the shifter returns to IDLE with the FIFO empty, and falls one cycle after a push.

## Structure
- Shared package `trashbin_periph_pkg`:
  - Register offset constants: `UART_REG_TXDATA`=0, `UART_REG_STATUS`=1, `UART_REG_BAUDDIV`=2.
  - STATUS bit positions.
  - Shifter state enum {IDLE, START, DATA, STOP}.
- Sub-module `uart_tx_fifo`:
  - Parameterised synchronous FIFO with push, pop, full, empty, count and same-edge push/pop rules.
  - Pointers wrap modulo `FifoDepth`. Count is one bit wider than the pointers.
- The top level contains decode, registers, shifter FSM and baud counter.

## Test plan
- Reset, then read STATUS and BAUDDIV: values 0x0000_0004 and `DefaultDivisor`; `TxOut`=1, `TxIrq`=1.
- BAUDDIV=3, write 0xA5:
  - `TxOut` low 4 cycles starting 2 edges after the write.
  - Then 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then high 4 cycles.
  - `TxIrq` rises 1 cycle after the frame ends (40 cycles total).
- BAUDDIV=100, 10 back-to-back writes 0x00..0x09:
  - Byte 0 enters the shifter, 8 are queued, 0x09 is dropped.
  - STATUS shows count=8, Full=1, Overflow=1.
  - The next STATUS read shows Overflow=0.
  - The line carries 0x00..0x08 in order.
- Write BAUDDIV=7 during a BAUDDIV=3 frame with a second byte queued: first frame 40 cycles, second frame 80 cycles.
- Assert `Reset` in the DATA state: `TxOut`=1 immediately, STATUS reads 0x0000_0004 afterwards, and the queued bytes are never sent.
- Read with an address outside the block and with offset 3: `DataReadBus_P`=0. Writes to these addresses change no state.
